// File: rtl/vc_traffic_gen.sv
// vc_traffic_gen: per-VC LFSR-driven packet sources that request an arbiter and stream flits once granted.
// Optional macro TG_STATS_EN adds saturating packet/flit counters (pkt_cnt_o, flit_cnt_o).
module vc_traffic_gen #(
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  parameter int output_num = 8,
  parameter int LEN_MAX    = 16,
  parameter int DATA_W     = 32,
  localparam int NVC = vc_num * prio_num,
  localparam int DW  = $clog2(output_num),
  localparam int VW  = $clog2(NVC),
  localparam int LW  = $clog2(LEN_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [7:0]               inject_thresh,
  input  logic                     fixed_mode,
  input  logic [DW-1:0]            fixed_dest,
  input  logic [15:0]              seed,
  input  logic                     cts,
  input  logic [VW-1:0]            selected_vc,
  input  logic                     flit_ready,
  output logic [NVC-1:0]           o_has_packet,
  output logic [NVC-1:0][DW-1:0]   dest_o,
  output logic [NVC-1:0][VW-1:0]   output_vc_o,
  output logic                     flit_valid,
  output logic                     flit_last,
  output logic [VW-1:0]            flit_vc,
  output logic [DATA_W-1:0]        flit_data,
`ifdef TG_STATS_EN
  output logic [NVC-1:0][31:0]     pkt_cnt_o,
  output logic [31:0]              flit_cnt_o,
`endif
  output logic [NVC-1:0][1:0]      dbg_state_o
);

  // Handshake: a flit moves on a cycle where flit_valid && flit_ready; while
  // flit_valid && !flit_ready the flit outputs are held unchanged.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e        state_q [NVC];
  state_e        state_d [NVC];
  logic [15:0]   lfsr_q  [NVC];
  logic [15:0]   lfsr_d  [NVC];
  logic [15:0]   lfsr_rst[NVC];
  logic [DW-1:0] dest_q  [NVC];
  logic [DW-1:0] dest_d  [NVC];
  logic [VW-1:0] ovc_q   [NVC];
  logic [VW-1:0] ovc_d   [NVC];
  logic [LW-1:0] rem_q   [NVC];
  logic [LW-1:0] rem_d   [NVC];
  logic [7:0]    idx_q   [NVC];
  logic [7:0]    idx_d   [NVC];
  logic [15:0]   seq_q   [NVC];
  logic [15:0]   seq_d   [NVC];

  logic          any_send;
  logic [VW-1:0] send_vc;
  logic [LW-1:0] send_rem;
  logic [7:0]    send_idx;
  logic [15:0]   send_seq;
  logic          send_last;
  logic          xfer;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // At most one VC is ever in SEND, so a simple scan finds the owner.
  always_comb begin
    any_send = 1'b0;
    send_vc  = '0;
    send_rem = '0;
    send_idx = '0;
    send_seq = '0;
    for (int i = 0; i < NVC; i++) begin
      if (state_q[i] == ST_SEND) begin
        any_send = 1'b1;
        send_vc  = VW'(i);
        send_rem = rem_q[i];
        send_idx = idx_q[i];
        send_seq = seq_q[i];
      end
    end
    send_last = any_send && (send_rem == LW'(1));
    xfer      = any_send && flit_ready;
  end

  always_comb begin
    for (int i = 0; i < NVC; i++) begin
      state_d[i]  = state_q[i];
      lfsr_d[i]   = lfsr_next(lfsr_q[i]);
      lfsr_rst[i] = ((seed ^ 16'(i + 1)) == 16'h0000) ? 16'h0001 : (seed ^ 16'(i + 1));
      dest_d[i]   = dest_q[i];
      ovc_d[i]    = ovc_q[i];
      rem_d[i]    = rem_q[i];
      idx_d[i]    = idx_q[i];
      seq_d[i]    = seq_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (enable && (lfsr_q[i][7:0] < inject_thresh)) begin
            state_d[i] = ST_REQ;
            idx_d[i]   = 8'd0;
            if (fixed_mode) begin
              dest_d[i] = fixed_dest;
              ovc_d[i]  = VW'(i);
              rem_d[i]  = LW'(LEN_MAX);
            end else begin
              dest_d[i] = DW'(32'(lfsr_q[i][15:8]) % output_num);
              ovc_d[i]  = VW'(32'(lfsr_q[i][15:8]) % NVC);
              rem_d[i]  = LW'(1 + (32'(lfsr_q[i][11:4]) % LEN_MAX));
            end
          end
        end
        ST_REQ: begin
          if (cts && (selected_vc == VW'(i)) && !any_send) begin
            state_d[i] = ST_SEND;
          end
        end
        ST_SEND: begin
          if (flit_ready) begin
            idx_d[i] = idx_q[i] + 8'd1;
            rem_d[i] = rem_q[i] - LW'(1);
            if (rem_q[i] == LW'(1)) begin
              state_d[i] = ST_IDLE;
              seq_d[i]   = seq_q[i] + 16'd1;
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NVC; i++) begin
        state_q[i] <= ST_IDLE;
        lfsr_q[i]  <= lfsr_rst[i];
        dest_q[i]  <= '0;
        ovc_q[i]   <= '0;
        rem_q[i]   <= '0;
        idx_q[i]   <= '0;
        seq_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NVC; i++) begin
        state_q[i] <= state_d[i];
        lfsr_q[i]  <= lfsr_d[i];
        dest_q[i]  <= dest_d[i];
        ovc_q[i]   <= ovc_d[i];
        rem_q[i]   <= rem_d[i];
        idx_q[i]   <= idx_d[i];
        seq_q[i]   <= seq_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NVC; i++) begin
      o_has_packet[i] = (state_q[i] == ST_REQ);
      dest_o[i]       = dest_q[i];
      output_vc_o[i]  = ovc_q[i];
      dbg_state_o[i]  = state_q[i];
    end
    flit_valid = any_send;
    flit_last  = send_last;
    flit_vc    = send_vc;
    flit_data  = any_send ? DATA_W'({send_seq, send_idx}) : '0;
  end

`ifdef TG_STATS_EN
  logic [NVC-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0]          flit_cnt_q, flit_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    flit_cnt_d = flit_cnt_q;
    if (xfer && (flit_cnt_q != '1)) flit_cnt_d = flit_cnt_q + 32'd1;
    for (int i = 0; i < NVC; i++) begin
      if (xfer && send_last && (send_vc == VW'(i)) && (pkt_cnt_q[i] != '1)) begin
        pkt_cnt_d[i] = pkt_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      flit_cnt_q <= flit_cnt_d;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign flit_cnt_o = flit_cnt_q;
`endif

endmodule

// File: tb/tb_vc_traffic_gen.sv
// Directed bench for vc_traffic_gen: reset, injection threshold, random/fixed packets, stalls, grant blocking, mid-packet reset.
module tb_vc_traffic_gen;
  localparam int NVC    = 6;
  localparam int DW     = 3;
  localparam int VW     = 3;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   enable;
  logic [7:0]             inject_thresh;
  logic                   fixed_mode;
  logic [DW-1:0]          fixed_dest;
  logic [15:0]            seed;
  logic                   cts;
  logic [VW-1:0]          selected_vc;
  logic                   flit_ready;
  logic [NVC-1:0]         o_has_packet;
  logic [NVC-1:0][DW-1:0] dest_o;
  logic [NVC-1:0][VW-1:0] output_vc_o;
  logic                   flit_valid;
  logic                   flit_last;
  logic [VW-1:0]          flit_vc;
  logic [DATA_W-1:0]      flit_data;
  logic [NVC-1:0][1:0]    dbg_state_o;
`ifdef TG_STATS_EN
  logic [NVC-1:0][31:0]   pkt_cnt_o;
  logic [31:0]            flit_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vc_traffic_gen dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .inject_thresh(inject_thresh),
    .fixed_mode   (fixed_mode),
    .fixed_dest   (fixed_dest),
    .seed         (seed),
    .cts          (cts),
    .selected_vc  (selected_vc),
    .flit_ready   (flit_ready),
    .o_has_packet (o_has_packet),
    .dest_o       (dest_o),
    .output_vc_o  (output_vc_o),
    .flit_valid   (flit_valid),
    .flit_last    (flit_last),
    .flit_vc      (flit_vc),
    .flit_data    (flit_data),
`ifdef TG_STATS_EN
    .pkt_cnt_o    (pkt_cnt_o),
    .flit_cnt_o   (flit_cnt_o),
`endif
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic do_reset(input logic [15:0] s, input logic [7:0] th, input logic fm, input logic en);
    @(negedge clk);
    resetn = 1'b0; seed = s; inject_thresh = th; fixed_mode = fm; enable = en;
    fixed_dest = 3'd5; cts = 1'b0; selected_vc = '0; flit_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_req(input int vc);
    int n;
    n = 0;
    while (!o_has_packet[vc] && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (o_has_packet[vc] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_req_vc%0d: has_packet=%b required 1 within 200 cycles", vc, o_has_packet[vc]);
    end
  endtask

  task automatic grant(input int vc);
    cts = 1'b1;
    selected_vc = VW'(vc);
    @(negedge clk);
    cts = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    @(negedge clk);
    resetn = 1'b0; seed = 16'h0000; inject_thresh = 8'd0; fixed_mode = 1'b0; enable = 1'b1;
    fixed_dest = 3'd0; cts = 1'b0; selected_vc = '0; flit_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (o_has_packet !== '0) begin n_fail++; $display("FAIL reset_has_packet: got %b required 0", o_has_packet); end
    n_tests++;
    if (flit_valid !== 1'b0 || flit_last !== 1'b0) begin
      n_fail++; $display("FAIL reset_flit_ctrl: valid=%b last=%b required 0 0", flit_valid, flit_last);
    end
    n_tests++;
    if (flit_data !== '0 || flit_vc !== '0) begin
      n_fail++; $display("FAIL reset_flit_data: data=%h vc=%0d required 0 0", flit_data, flit_vc);
    end
    n_tests++;
    if (dest_o !== '0 || output_vc_o !== '0) begin
      n_fail++; $display("FAIL reset_dest_ovc: dest=%h ovc=%h required 0 0", dest_o, output_vc_o);
    end
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_has_packet !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL thresh0_no_inject: %0d cycles with requests, required 0", bad); end
    n_tests++;
    if (dbg_state_o !== '0) begin n_fail++; $display("FAIL thresh0_idle: state=%h required 0", dbg_state_o); end
  endtask

  // seed 0: lfsr[i]=i+1, so every VC injects at once with dest 0, out_vc 0, len 1
  task automatic test_one_flit();
    do_reset(16'h0000, 8'd255, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (o_has_packet !== 6'h3F) begin n_fail++; $display("FAIL seed0_inject: got %b required 111111", o_has_packet); end
    n_tests++;
    if (dest_o !== '0 || output_vc_o !== '0) begin
      n_fail++; $display("FAIL seed0_latch: dest=%h ovc=%h required 0 0", dest_o, output_vc_o);
    end
    grant(5);
    n_tests++;
    if (flit_valid !== 1'b1 || flit_last !== 1'b1 || flit_vc !== 3'd5 || flit_data !== 32'h0) begin
      n_fail++;
      $display("FAIL one_flit: valid=%b last=%b vc=%0d data=%h required 1 1 5 0", flit_valid, flit_last, flit_vc, flit_data);
    end
    flit_ready = 1'b1;
    @(negedge clk);
    flit_ready = 1'b0;
    n_tests++;
    if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL one_flit_done: valid=%b required 0", flit_valid); end
  endtask

  // seed A5C3: lfsr[i] low bytes C2,C1,C0,C7,C6,C5; upper A5 -> dest 5, out_vc 3; bits[11:4]=5C -> len 13
  task automatic test_thresh();
    do_reset(16'hA5C3, 8'hC2, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (o_has_packet !== 6'b000110) begin n_fail++; $display("FAIL thresh_c2: got %b required 000110", o_has_packet); end
    n_tests++;
    if (dest_o[1] !== 3'd5 || output_vc_o[1] !== 3'd3) begin
      n_fail++; $display("FAIL thresh_latch: dest=%0d ovc=%0d required 5 3", dest_o[1], output_vc_o[1]);
    end
  endtask

  task automatic test_random_len();
    int cnt, bad, got_last;
    do_reset(16'hA5C3, 8'd255, 1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (o_has_packet !== 6'h3F) begin n_fail++; $display("FAIL rand_inject: got %b required 111111", o_has_packet); end
    grant(0);
    flit_ready = 1'b1;
    cnt = 0; bad = 0; got_last = 0;
    for (int c = 0; c < 40 && got_last == 0; c++) begin
      if (flit_valid) begin
        if (flit_data !== DATA_W'(cnt) || flit_vc !== 3'd0) bad++;
        if (dest_o[0] !== 3'd5 || output_vc_o[0] !== 3'd3) bad++;
        if (flit_last) got_last = 1;
        cnt++;
      end
      @(negedge clk);
    end
    flit_ready = 1'b0;
    n_tests++;
    if (cnt != 13 || got_last != 1) begin n_fail++; $display("FAIL rand_len: got %0d flits last=%0d required 13 1", cnt, got_last); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rand_flits: %0d bad flit samples, required 0", bad); end
  endtask

  task automatic test_fixed_stream();
    int bad;
    do_reset(16'hA5C3, 8'd255, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++;
    if (dest_o[2] !== 3'd5 || output_vc_o[2] !== 3'd2) begin
      n_fail++; $display("FAIL fixed_latch: dest=%0d ovc=%0d required 5 2", dest_o[2], output_vc_o[2]);
    end
    grant(2);
    flit_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (flit_valid !== 1'b1 || flit_vc !== 3'd2 || flit_data !== DATA_W'(k)) bad++;
      if (flit_last !== (k == 15)) bad++;
      if (dest_o[2] !== 3'd5 || output_vc_o[2] !== 3'd2) bad++;
      @(negedge clk);
    end
    flit_ready = 1'b0;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL fixed_stream: %0d bad flit samples, required 0", bad); end
    n_tests++;
    if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_len: valid=%b after 16 flits, required 0", flit_valid); end
  endtask

  // VC 0 has been waiting in REQ since the fixed-mode reset
  task automatic test_stall();
    int xfers, bad, done, prev_stall;
    logic rpat;
    logic [DATA_W-1:0] s_data;
    logic s_last;
    logic [VW-1:0] s_vc;
    grant(0);
    xfers = 0; bad = 0; done = 0; prev_stall = 0; rpat = 1'b1;
    s_data = '0; s_last = 1'b0; s_vc = '0;
    for (int c = 0; c < 80 && done == 0; c++) begin
      if (prev_stall != 0 && (flit_data !== s_data || flit_last !== s_last || flit_vc !== s_vc)) bad++;
      if (dest_o[0] !== 3'd5 || output_vc_o[0] !== 3'd0) bad++;
      flit_ready = rpat;
      prev_stall = 0;
      if (flit_valid) begin
        if (flit_data !== DATA_W'(xfers)) bad++;
        if (rpat) begin
          xfers++;
          if (flit_last) done = 1;
        end else begin
          prev_stall = 1;
          s_data = flit_data; s_last = flit_last; s_vc = flit_vc;
        end
      end
      rpat = ~rpat;
      @(negedge clk);
    end
    flit_ready = 1'b0;
    n_tests++;
    if (xfers != 16) begin n_fail++; $display("FAIL stall_count: got %0d transfers required 16", xfers); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable samples, required 0", bad); end
  endtask

  task automatic test_blocked_grant();
    int done;
    grant(1);
    cts = 1'b1;
    selected_vc = 3'd3;
    @(negedge clk);
    cts = 1'b0;
    n_tests++;
    if (o_has_packet[3] !== 1'b1 || dbg_state_o[3] !== 2'd1 || flit_vc !== 3'd1) begin
      n_fail++;
      $display("FAIL blocked_grant: req3=%b state3=%0d flit_vc=%0d required 1 1 1", o_has_packet[3], dbg_state_o[3], flit_vc);
    end
    flit_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 40 && done == 0; c++) begin
      if (flit_valid && flit_last) done = 1;
      @(negedge clk);
    end
    flit_ready = 1'b0;
    n_tests++;
    if (done != 1 || flit_valid !== 1'b0) begin
      n_fail++; $display("FAIL vc1_finish: last_seen=%0d valid=%b required 1 0", done, flit_valid);
    end
    cts = 1'b1;
    selected_vc = 3'd7;
    @(negedge clk);
    cts = 1'b0;
    n_tests++;
    if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL bad_sel_ignored: valid=%b required 0", flit_valid); end
    grant(3);
    n_tests++;
    if (flit_valid !== 1'b1 || flit_vc !== 3'd3 || output_vc_o[3] !== 3'd3) begin
      n_fail++; $display("FAIL regrant_vc3: valid=%b vc=%0d ovc=%0d required 1 3 3", flit_valid, flit_vc, output_vc_o[3]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'hA5C3, 8'd255, 1'b1, 1'b1);
    @(negedge clk);
    grant(0);
    flit_ready = 1'b1;
    repeat (16) @(negedge clk);
    flit_ready = 1'b0;
    wait_req(0);
    grant(0);
    n_tests++;
    if (flit_data !== 32'h0000_0100) begin n_fail++; $display("FAIL seq_incr: data=%h required 00000100", flit_data); end
    flit_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (flit_data !== 32'h0000_0104 || flit_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_flit4: data=%h valid=%b required 00000104 1", flit_data, flit_valid);
    end
    resetn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (flit_valid !== 1'b0 || flit_last !== 1'b0 || dbg_state_o !== '0 || o_has_packet !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b last=%b state=%h req=%b required 0 0 0 0", flit_valid, flit_last, dbg_state_o, o_has_packet);
    end
    flit_ready = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    grant(0);
    n_tests++;
    if (flit_valid !== 1'b1 || flit_data !== 32'h0) begin
      n_fail++; $display("FAIL seq_cleared: valid=%b data=%h required 1 0", flit_valid, flit_data);
    end
  endtask

`ifdef TG_STATS_EN
  task automatic test_stats();
    do_reset(16'hA5C3, 8'd255, 1'b1, 1'b1);
    @(negedge clk);
    for (int p = 0; p < 10; p++) begin
      wait_req(4);
      grant(4);
      flit_ready = 1'b1;
      repeat (16) @(negedge clk);
      flit_ready = 1'b0;
    end
    n_tests++;
    if (pkt_cnt_o[4] !== 32'd10 || pkt_cnt_o[0] !== 32'd0) begin
      n_fail++; $display("FAIL stats_pkt: vc4=%0d vc0=%0d required 10 0", pkt_cnt_o[4], pkt_cnt_o[0]);
    end
    n_tests++;
    if (flit_cnt_o !== 32'd160) begin n_fail++; $display("FAIL stats_flit: got %0d required 160", flit_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_one_flit();
    test_thresh();
    test_random_len();
    test_fixed_stream();
    test_stall();
    test_blocked_grant();
    test_reset_mid();
`ifdef TG_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
